regfile_op_sequencer: RTL and testbench

//  Initiator-side controller for the team's register bank (2 comb. read ports, 1 sync write port, reg 0 reads 0).

---
 rtl/regfile_op_sequencer.sv | 277 +++++++++++++++++++++++++++
 tb/tb_regfile_op_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_op_sequencer.sv
// regfile_op_sequencer
// Initiator-side controller for a register bank. The bank has two combinational
// read ports and one synchronous write port, and register 0 always reads as 0.
// The controller accepts one register-to-register operation per request, fetches
// its operands from the bank, runs the ALU, writes the result back and returns it
// on a valid/ready response channel.
// Sequence: IDLE -> READ -> EXEC -> WRITE -> RESP -> IDLE.
// Every output is registered. Each output register is loaded from the state the
// FSM is about to enter, so the outputs line up with that state's cycle.
// Optional feature: define STATUS_FLAGS_EN to enable the zero and carry/borrow
// flags. When it is not defined, flag_zero_o and flag_carry_o are tied to 0.
module regfile_op_sequencer #(
    parameter int N = 8,
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic [2:0]   req_op_i,
    input  logic [N-1:0] req_rs1_i,
    input  logic [N-1:0] req_rs2_i,
    input  logic [N-1:0] req_rd_i,
    input  logic [W-1:0] req_imm_i,
    output logic [N-1:0] bank_addr_rs1_o,
    output logic [N-1:0] bank_addr_rs2_o,
    output logic [N-1:0] bank_addr_rd_o,
    output logic [W-1:0] bank_data_o,
    output logic         bank_we_o,
    input  logic [W-1:0] bank_rs1_i,
    input  logic [W-1:0] bank_rs2_i,
    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output logic [W-1:0] rsp_data_o,
    output logic         flag_zero_o,
    output logic         flag_carry_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_MOVI = 3'd5;
    localparam logic [2:0] OP_MOV  = 3'd6;
    localparam logic [2:0] OP_CMP  = 3'd7;

    // ALU result, modulo 2**W. CMP computes the same difference as SUB.
    function automatic logic [W-1:0] alu_result(
        input logic [2:0]   op,
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic [W-1:0] imm
    );
        logic [W-1:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_MOVI: r = imm;
            OP_MOV:  r = a;
            OP_CMP:  r = a - b;
            default: r = {W{1'b0}};
        endcase
        return r;
    endfunction

    state_t       state_q, state_d;
    logic [2:0]   op_q, op_d;
    logic [N-1:0] rd_q, rd_d;
    logic [W-1:0] imm_q, imm_d;
    logic [W-1:0] opa_q, opa_d;
    logic [W-1:0] opb_q, opb_d;
    logic [W-1:0] result_q, result_d;
    logic         req_ready_q, req_ready_d;
    logic [N-1:0] addr_rs1_q, addr_rs1_d;
    logic [N-1:0] addr_rs2_q, addr_rs2_d;
    logic [N-1:0] addr_rd_q, addr_rd_d;
    logic [W-1:0] bank_data_q, bank_data_d;
    logic         bank_we_q, bank_we_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic [W-1:0] rsp_data_q, rsp_data_d;
    logic [W-1:0] alu_res_s;

    assign alu_res_s = alu_result(op_q, opa_q, opb_q, imm_q);

    // Next-state logic and datapath register loads, one step per state
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        imm_d    = imm_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i && req_ready_q) begin
                    op_d    = req_op_i;
                    rd_d    = req_rd_i;
                    imm_d   = req_imm_i;
                    state_d = S_READ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                opa_d   = bank_rs1_i;
                opb_d   = bank_rs2_i;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                result_d = alu_res_s;
                state_d  = S_WRITE;
            end
            S_WRITE: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output register loads, decoded from the state being entered; bus stays 0 elsewhere
    always_comb begin
        req_ready_d = (state_d == S_IDLE);
        addr_rs1_d  = {N{1'b0}};
        addr_rs2_d  = {N{1'b0}};
        addr_rd_d   = {N{1'b0}};
        bank_data_d = {W{1'b0}};
        bank_we_d   = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = {W{1'b0}};
        case (state_d)
            S_READ: begin
                // READ is only ever entered from an accept, so the request fields are live
                addr_rs1_d = req_rs1_i;
                addr_rs2_d = req_rs2_i;
            end
            S_WRITE: begin
                addr_rd_d   = rd_q;
                bank_data_d = result_d;
                bank_we_d   = (rd_q != {N{1'b0}}) && (op_q != OP_CMP);
            end
            S_RESP: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = result_d;
            end
            default: begin
                addr_rs1_d = {N{1'b0}};
            end
        endcase
    end

    // State, datapath and output registers; reset drops any operation in flight
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            op_q        <= 3'd0;
            rd_q        <= {N{1'b0}};
            imm_q       <= {W{1'b0}};
            opa_q       <= {W{1'b0}};
            opb_q       <= {W{1'b0}};
            result_q    <= {W{1'b0}};
            req_ready_q <= 1'b0;
            addr_rs1_q  <= {N{1'b0}};
            addr_rs2_q  <= {N{1'b0}};
            addr_rd_q   <= {N{1'b0}};
            bank_data_q <= {W{1'b0}};
            bank_we_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= {W{1'b0}};
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            imm_q       <= imm_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            result_q    <= result_d;
            req_ready_q <= req_ready_d;
            addr_rs1_q  <= addr_rs1_d;
            addr_rs2_q  <= addr_rs2_d;
            addr_rd_q   <= addr_rd_d;
            bank_data_q <= bank_data_d;
            bank_we_q   <= bank_we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign req_ready_o     = req_ready_q;
    assign bank_addr_rs1_o = addr_rs1_q;
    assign bank_addr_rs2_o = addr_rs2_q;
    assign bank_addr_rd_o  = addr_rd_q;
    assign bank_data_o     = bank_data_q;
    assign bank_we_o       = bank_we_q;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_data_o      = rsp_data_q;

`ifdef STATUS_FLAGS_EN
    // Carry-out for ADD, borrow (A < B) for SUB/CMP, 0 for all other ops
    function automatic logic alu_carry(
        input logic [2:0]   op,
        input logic [W-1:0] a,
        input logic [W-1:0] b
    );
        logic [W:0] wide;
        logic       c;
        case (op)
            OP_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                c    = wide[W];
            end
            OP_SUB, OP_CMP: begin
                c = (a < b);
            end
            default: begin
                c = 1'b0;
            end
        endcase
        return c;
    endfunction

    logic flag_zero_q, flag_zero_d;
    logic flag_carry_q, flag_carry_d;

    // Flags are sampled with the result in EXEC and held until the next EXEC
    always_comb begin
        flag_zero_d  = flag_zero_q;
        flag_carry_d = flag_carry_q;
        if (state_q == S_EXEC) begin
            flag_zero_d  = (alu_res_s == {W{1'b0}});
            flag_carry_d = alu_carry(op_q, opa_q, opb_q);
        end else begin
            flag_zero_d  = flag_zero_q;
            flag_carry_d = flag_carry_q;
        end
    end

    // Flag registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flag_zero_q  <= 1'b0;
            flag_carry_q <= 1'b0;
        end else begin
            flag_zero_q  <= flag_zero_d;
            flag_carry_q <= flag_carry_d;
        end
    end

    assign flag_zero_o  = flag_zero_q;
    assign flag_carry_o = flag_carry_q;
`else
    assign flag_zero_o  = 1'b0;
    assign flag_carry_o = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Self-checking bench for regfile_op_sequencer.
// Includes a behavioural register bank: two combinational read ports, one
// synchronous write port, and register 0 always reads as 0.
// For every request, the expected response and the expected bank write (if any)
// are computed from an array model of the registers and pushed into queues.
// A negedge monitor pops and compares these entries whenever the DUT writes or
// completes a response handshake.
module tb_regfile_op_sequencer;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic [7:0] req_rs1, req_rs2, req_rd, req_imm;
    logic [7:0] bank_addr_rs1, bank_addr_rs2, bank_addr_rd, bank_data;
    logic       bank_we;
    logic [7:0] bank_rs1, bank_rs2;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       flag_zero, flag_carry;

    regfile_op_sequencer #(.N(8), .W(8)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_op_i        (req_op),
        .req_rs1_i       (req_rs1),
        .req_rs2_i       (req_rs2),
        .req_rd_i        (req_rd),
        .req_imm_i       (req_imm),
        .bank_addr_rs1_o (bank_addr_rs1),
        .bank_addr_rs2_o (bank_addr_rs2),
        .bank_addr_rd_o  (bank_addr_rd),
        .bank_data_o     (bank_data),
        .bank_we_o       (bank_we),
        .bank_rs1_i      (bank_rs1),
        .bank_rs2_i      (bank_rs2),
        .rsp_valid_o     (rsp_valid),
        .rsp_ready_i     (rsp_ready),
        .rsp_data_o      (rsp_data),
        .flag_zero_o     (flag_zero),
        .flag_carry_o    (flag_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- register bank environment ----------------
    logic [7:0] bank_mem [256];
    assign bank_rs1 = (bank_addr_rs1 == 8'd0) ? 8'd0 : bank_mem[bank_addr_rs1];
    assign bank_rs2 = (bank_addr_rs2 == 8'd0) ? 8'd0 : bank_mem[bank_addr_rs2];

    initial begin
        for (int i = 0; i < 256; i++) bank_mem[i] = 8'(i * 37);
        forever begin
            @(posedge clk);
            if (bank_we && bank_addr_rd != 8'd0) bank_mem[bank_addr_rd] <= bank_data;
        end
    end

    // ---------------- checking infrastructure ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct { logic [7:0] data; logic z; logic c; } rsp_t;
    typedef struct { logic [7:0] addr; logic [7:0] data; } wr_t;
    rsp_t rsp_q[$];
    wr_t  wr_q[$];

    // Architectural register model; initial contents match the bank's power-up pattern
    logic [7:0] model_regs [256];
    initial for (int i = 0; i < 256; i++) model_regs[i] = 8'(i * 37);

    int acc_cyc = 0;

    // Reference model: plain integer arithmetic on architectural registers
    task automatic model_op(input logic [2:0] op, input logic [7:0] rs1, input logic [7:0] rs2,
                            input logic [7:0] rd, input logic [7:0] imm);
        int a, b, r;
        bit c;
        rsp_t e;
        wr_t  w;
        a = (rs1 == 8'd0) ? 0 : int'(model_regs[rs1]);
        b = (rs2 == 8'd0) ? 0 : int'(model_regs[rs2]);
        c = 1'b0;
        case (op)
            3'd0: begin r = a + b; c = (r > 255); end
            3'd1, 3'd7: begin r = a - b; c = (a < b); if (r < 0) r = r + 256; end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = int'(imm);
            3'd6: r = a;
            default: r = 0;
        endcase
        r = r % 256;
        e.data = 8'(r);
`ifdef STATUS_FLAGS_EN
        e.z = (r == 0);
        e.c = c;
`else
        e.z = 1'b0;
        e.c = 1'b0;
`endif
        rsp_q.push_back(e);
        if (op != 3'd7 && rd != 8'd0) begin
            w.addr = rd;
            w.data = 8'(r);
            wr_q.push_back(w);
            model_regs[rd] = 8'(r);
        end
    endtask

    // ---------------- monitor ----------------
    logic       prev_valid = 1'b0;
    logic [7:0] prev_data  = 8'd0;

    // Pops expectations on writes and response handshakes; checks timing and stability
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
        end else begin
            if (bank_we) begin
                if (wr_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_write: bank_we=1 addr %0h data %0h, expected no write", bank_addr_rd, bank_data);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk("write_addr", 64'(bank_addr_rd), 64'(w.addr));
                    chk("write_data", 64'(bank_data), 64'(w.data));
                    chk("write_cycle", 64'(cyc - acc_cyc), 64'd2);
                end
            end
            if (req_ready)
                chk("idle_outputs", {22'd0, bank_addr_rs1, bank_addr_rs2, bank_addr_rd, bank_data,
                                     bank_we, rsp_valid, rsp_data}, 64'd0);
            if (rsp_valid && !prev_valid) chk("rsp_latency", 64'(cyc - acc_cyc), 64'd3);
            if (rsp_valid && prev_valid) chk("rsp_stable", 64'(rsp_data), 64'(prev_data));
            if (rsp_valid) chk("ready_low_in_resp", 64'(req_ready), 64'd0);
            if (rsp_valid && rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_rsp: data %0h, expected no response", rsp_data);
                end else begin
                    rsp_t e;
                    e = rsp_q.pop_front();
                    chk("rsp_data", 64'(rsp_data), 64'(e.data));
                    chk("flag_zero", 64'(flag_zero), 64'(e.z));
                    chk("flag_carry", 64'(flag_carry), 64'(e.c));
                end
            end
            prev_valid <= rsp_valid;
            prev_data  <= rsp_data;
        end
    end

    // ---------------- driver ----------------
    task automatic junk_req();
        req_valid = 1'($urandom_range(0, 1));
        req_op    = 3'($urandom_range(0, 7));
        req_rs1   = 8'($urandom_range(0, 255));
        req_rs2   = 8'($urandom_range(0, 255));
        req_rd    = 8'($urandom_range(0, 255));
        req_imm   = 8'($urandom_range(0, 255));
    endtask

    // Issues one operation, drives junk while busy, stalls the response, then consumes it
    task automatic do_op(input logic [2:0] op, input logic [7:0] rs1, input logic [7:0] rs2,
                         input logic [7:0] rd, input logic [7:0] imm, input int stall);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk("req_ready_wait", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_op = op; req_rs1 = rs1; req_rs2 = rs2; req_rd = rd; req_imm = imm;
        model_op(op, rs1, rs2, rd, imm);
        @(posedge clk); #1;
        acc_cyc = cyc;
        n = 0;
        while (!rsp_valid && n < 20) begin
            junk_req();
            rsp_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        chk("rsp_valid_wait", 64'(rsp_valid), 64'd1);
        rsp_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            junk_req();
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("ready_after_rsp", 64'(req_ready), 64'd1);
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main stimulus ----------------
    initial begin
        logic [7:0] old9;
        int n;
        req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = 3'd0; req_rs1 = 8'd0; req_rs2 = 8'd0; req_rd = 8'd0; req_imm = 8'd0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 64'(req_ready), 64'd0);
        chk("reset_outputs", {20'd0, bank_addr_rs1, bank_addr_rs2, bank_addr_rd, bank_data,
                              bank_we, rsp_valid, rsp_data, flag_zero, flag_carry}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        chk("ready_first_edge", 64'(req_ready), 64'd1);

        // MOVI then dependent ADD (0x5A + 0x5A = 0xB4)
        do_op(3'd5, 8'd0, 8'd0, 8'd3, 8'h5A, 0);
        do_op(3'd0, 8'd3, 8'd3, 8'd4, 8'h00, 1);
        // ADD with carry-out and SUB with borrow
        do_op(3'd5, 8'd0, 8'd0, 8'd10, 8'hF0, 0);
        do_op(3'd5, 8'd0, 8'd0, 8'd11, 8'h20, 0);
        do_op(3'd0, 8'd10, 8'd11, 8'd12, 8'h00, 0);
        do_op(3'd5, 8'd0, 8'd0, 8'd13, 8'h10, 0);
        do_op(3'd1, 8'd13, 8'd11, 8'd14, 8'h00, 2);
        // CMP of a register with itself: no write, result 0
        do_op(3'd7, 8'd5, 8'd5, 8'd6, 8'h00, 0);
        // MOV into reg 0 is not written; reg 0 then reads as 0
        do_op(3'd5, 8'd0, 8'd0, 8'd6, 8'h77, 0);
        do_op(3'd6, 8'd6, 8'd0, 8'd0, 8'h00, 0);
        do_op(3'd6, 8'd0, 8'd0, 8'd7, 8'h00, 0);
        // Long response stall with junk requests present
        do_op(3'd3, 8'd4, 8'd3, 8'd8, 8'h00, 6);

        // Reset asserted during the WRITE cycle
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        old9 = model_regs[9];
        req_valid = 1'b1; req_op = 3'd0; req_rs1 = 8'd3; req_rs2 = 8'd3; req_rd = 8'd9; req_imm = 8'd0;
        model_op(3'd0, 8'd3, 8'd3, 8'd9, 8'd0);
        @(posedge clk); #1;
        acc_cyc = cyc;
        req_valid = 1'b0;
        n = 0;
        while (!bank_we && n < 10) begin @(posedge clk); #1; n++; end
        chk("we_before_reset", 64'(bank_we), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_we_drop", 64'(bank_we), 64'd0);
        chk("reset_ready_drop", 64'(req_ready), 64'd0);
        chk("reset_rsp_drop", 64'(rsp_valid), 64'd0);
        rsp_q.delete();
        wr_q.delete();
        model_regs[9] = old9;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("ready_low_after_release", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        chk("ready_after_release", 64'(req_ready), 64'd1);
        // Reg 9 must still hold its pre-reset value
        do_op(3'd6, 8'd9, 8'd0, 8'd15, 8'h00, 0);

        // Randomized operations over a small register window to create dependencies
        for (int k = 0; k < 60; k++) begin
            do_op(3'($urandom_range(0, 7)), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                  8'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), $urandom_range(0, 3));
        end

        repeat (5) @(posedge clk);
        #1;
        chk("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
        chk("wr_queue_drained", 64'(wr_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
